// File: rtl/enigma_controller.sv
// Sequences one Enigma encipherment per accepted letter: steps the rotor stack
// (with double-step), then walks a shared lookup unit through seven passes.
module enigma_controller #(
   parameter int          NUM_ROTORS = 5,
   parameter logic [39:0] NOTCH_POS  = {5'd0, 5'd0, 5'd0, 5'd25, 5'd9, 5'd21, 5'd4, 5'd16}
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rotor_valid_in,
   input  logic [8:0]  rotor_select_in,
   input  logic [14:0] rotor_initial_in,
   input  logic        letter_valid_in,
   input  logic [4:0]  char_in,
   output logic        lut_req_out,
   output logic [2:0]  lut_rotor_out,
   output logic        lut_reflect_out,
   output logic        lut_dir_out,
   output logic [4:0]  lut_index_out,
   input  logic        lut_ack_in,
   input  logic [4:0]  lut_data_in,
   output logic        cipher_valid_out,
   output logic [4:0]  cipher_out,
   output logic        busy_out,
   output logic [14:0] position_out,
   output logic        overflow_out,
   output logic        config_err_out
);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_STEP = 2'd1, S_LOOKUP = 2'd2} state_t;

   localparam logic [3:0] L_NUM_ROTORS = 4'(NUM_ROTORS);

   state_t      r_state;
   logic [2:0]  r_pass;
   logic [4:0]  r_char;
   logic [8:0]  r_sel;
   logic [14:0] r_pos;
   logic        r_req, r_reflect, r_dir, r_cipher_valid, r_overflow, r_config_err;
   logic [2:0]  r_rotor;
   logic [4:0]  r_index, r_cipher;

   function automatic logic [4:0] add_mod26(input logic [4:0] a, input logic [4:0] b);
      logic [5:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= 6'd26) s = s - 6'd26;
      return s[4:0];
   endfunction

   function automatic logic [4:0] sub_mod26(input logic [4:0] a, input logic [4:0] b);
      logic [5:0] d;
      d = {1'b0, a} - {1'b0, b};
      if (a < b) d = d + 6'd26;
      return d[4:0];
   endfunction

   function automatic logic [4:0] inc26(input logic [4:0] p);
      return (p == 5'd25) ? 5'd0 : p + 5'd1;
   endfunction

   function automatic logic [4:0] notch(input logic [2:0] t);
      return NOTCH_POS[{1'b0, t, 2'b00} + {3'b000, t} +: 5];
   endfunction

   // Passes k and 6-k use the same rotor: 0/6 right, 1/5 middle, 2/4 left.
   function automatic logic [1:0] pass_slot(input logic [2:0] p);
      case (p)
         3'd0, 3'd6: return 2'd0;
         3'd1, 3'd5: return 2'd1;
         default:    return 2'd2;
      endcase
   endfunction

   function automatic logic [4:0] slot_pos(input logic [14:0] word, input logic [1:0] s);
      case (s)
         2'd0:    return word[4:0];
         2'd1:    return word[9:5];
         default: return word[14:10];
      endcase
   endfunction

   function automatic logic [2:0] slot_type(input logic [8:0] sel, input logic [1:0] s);
      case (s)
         2'd0:    return sel[2:0];
         2'd1:    return sel[5:3];
         default: return sel[8:6];
      endcase
   endfunction

   logic [4:0]  w_pos_r, w_pos_m, w_pos_l;
   logic        w_turn_m, w_turn_l;
   logic [14:0] w_step_pos;
   logic [4:0]  w_result;
   logic [2:0]  w_load_pass, w_load_rotor;
   logic [4:0]  w_load_c, w_load_index;
   logic [14:0] w_load_word;
   logic [1:0]  w_load_slot;
   logic        w_cfg_bad;

   assign w_pos_r = r_pos[4:0];
   assign w_pos_m = r_pos[9:5];
   assign w_pos_l = r_pos[14:10];

   // A middle rotor sitting on its notch moves itself and the left rotor (double step).
   assign w_turn_l   = (w_pos_m == notch(r_sel[5:3]));
   assign w_turn_m   = (w_pos_r == notch(r_sel[2:0])) || w_turn_l;
   assign w_step_pos = {w_turn_l ? inc26(w_pos_l) : w_pos_l,
                        w_turn_m ? inc26(w_pos_m) : w_pos_m,
                        inc26(w_pos_r)};

   assign w_result = (r_pass == 3'd3) ? lut_data_in
                                      : sub_mod26(lut_data_in, slot_pos(r_pos, pass_slot(r_pass)));

   // Drive values for the pass about to be issued, either pass 0 out of STEP or the next one.
   always_comb begin
      w_load_pass = r_pass + 3'd1;
      w_load_c    = w_result;
      w_load_word = r_pos;
      if (r_state == S_STEP) begin
         w_load_pass = 3'd0;
         w_load_c    = r_char;
         w_load_word = w_step_pos;
      end
      w_load_slot  = pass_slot(w_load_pass);
      w_load_rotor = (w_load_pass == 3'd3) ? 3'd0 : slot_type(r_sel, w_load_slot);
      w_load_index = (w_load_pass == 3'd3) ? w_load_c
                                           : add_mod26(w_load_c, slot_pos(w_load_word, w_load_slot));
   end

   assign w_cfg_bad = ({1'b0, rotor_select_in[8:6]} >= L_NUM_ROTORS) ||
                      ({1'b0, rotor_select_in[5:3]} >= L_NUM_ROTORS) ||
                      ({1'b0, rotor_select_in[2:0]} >= L_NUM_ROTORS) ||
                      (rotor_initial_in[14:10] > 5'd25) ||
                      (rotor_initial_in[9:5]   > 5'd25) ||
                      (rotor_initial_in[4:0]   > 5'd25);

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state        <= S_IDLE;
         r_pass         <= 3'd0;
         r_char         <= 5'd0;
         r_sel          <= 9'b010_001_000;
         r_pos          <= 15'd0;
         r_req          <= 1'b0;
         r_rotor        <= 3'd0;
         r_reflect      <= 1'b0;
         r_dir          <= 1'b0;
         r_index        <= 5'd0;
         r_cipher_valid <= 1'b0;
         r_cipher       <= 5'd0;
         r_overflow     <= 1'b0;
         r_config_err   <= 1'b0;
      end else begin
         r_cipher_valid <= 1'b0;
         if (rotor_valid_in) begin
            r_sel        <= rotor_select_in;
            r_pos        <= rotor_initial_in;
            r_config_err <= w_cfg_bad;
            r_overflow   <= letter_valid_in;
            r_state      <= S_IDLE;
            r_req        <= 1'b0;
            r_pass       <= 3'd0;
         end else begin
            if (letter_valid_in && (r_state != S_IDLE || r_config_err)) r_overflow <= 1'b1;
            case (r_state)
               S_IDLE: begin
                  if (letter_valid_in && !r_config_err) begin
                     r_char  <= char_in;
                     r_state <= S_STEP;
                  end
               end
               S_STEP: begin
                  r_pos     <= w_step_pos;
                  r_pass    <= 3'd0;
                  r_req     <= 1'b1;
                  r_rotor   <= w_load_rotor;
                  r_reflect <= 1'b0;
                  r_dir     <= 1'b0;
                  r_index   <= w_load_index;
                  r_state   <= S_LOOKUP;
               end
               S_LOOKUP: begin
                  if (lut_ack_in) begin
                     if (r_pass == 3'd6) begin
                        r_cipher       <= w_result;
                        r_cipher_valid <= 1'b1;
                        r_req          <= 1'b0;
                        r_state        <= S_IDLE;
                     end else begin
                        r_char    <= w_result;
                        r_pass    <= w_load_pass;
                        r_rotor   <= w_load_rotor;
                        r_reflect <= (w_load_pass == 3'd3);
                        r_dir     <= (w_load_pass > 3'd3);
                        r_index   <= w_load_index;
                     end
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign lut_req_out      = r_req;
   assign lut_rotor_out    = r_rotor;
   assign lut_reflect_out  = r_reflect;
   assign lut_dir_out      = r_dir;
   assign lut_index_out    = r_index;
   assign cipher_valid_out = r_cipher_valid;
   assign cipher_out       = r_cipher;
   assign busy_out         = (r_state != S_IDLE);
   assign position_out     = r_pos;
   assign overflow_out     = r_overflow;
   assign config_err_out   = r_config_err;
endmodule
